// File: rtl/ca_pkg.sv
// Shared FSM encoding and default frame header for the CA seed loader.
package ca_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RULE   = 2'd1,
        DATA   = 2'd2,
        COMMIT = 2'd3
    } fsm_t;

    localparam logic [7:0] CA_HDR_DEFAULT = 8'hC5;

endpackage

// File: rtl/ca_loader.sv
// Parses HDR, rule, NBYTES LSB-first seed bytes from a byte stream and commits them to the CA array.
// Latency: set_state one cycle after last byte; backpressure: in_ready drops only in the COMMIT cycle.
module ca_loader
    import ca_pkg::*;
#(
    parameter int         WIDTH = 32,
    parameter logic [7:0] HDR   = CA_HDR_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [7:0]       in_data,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             abort,
    output logic [7:0]       rule,
    output logic [WIDTH-1:0] state,
    output logic             set_state,
    output logic             busy,
    output logic             err,
    output logic [7:0]       frames
);

    localparam int NBYTES = WIDTH / 8;
    localparam int IW     = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(NBYTES - 1);

    fsm_t             r_fsm;
    logic [IW-1:0]    r_idx;
    logic [7:0]       r_rule_sh;
    logic [WIDTH-1:0] r_state_sh;
    logic [7:0]       r_rule;
    logic [WIDTH-1:0] r_state;
    logic             r_set_state;
    logic             r_err;
    logic [7:0]       r_frames;
    logic             r_in_ready;

    logic             w_accept;
    logic [WIDTH-1:0] w_state_merged;

    assign w_accept = in_valid && r_in_ready;

    // Shadow with the incoming byte dropped into its slot, so the last byte commits directly.
    always_comb begin
        w_state_merged = r_state_sh;
        for (int k = 0; k < NBYTES; k++) begin
            if (r_idx == IW'(k)) begin
                w_state_merged[8*k +: 8] = in_data;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fsm       <= IDLE;
            r_idx       <= '0;
            r_rule_sh   <= '0;
            r_state_sh  <= '0;
            r_rule      <= '0;
            r_state     <= '0;
            r_set_state <= 1'b0;
            r_err       <= 1'b0;
            r_frames    <= '0;
            r_in_ready  <= 1'b0;
        end else begin
            r_set_state <= 1'b0;
            r_err       <= 1'b0;
            r_in_ready  <= 1'b1;
            if (abort) begin
                r_fsm      <= IDLE;
                r_idx      <= '0;
                r_rule_sh  <= '0;
                r_state_sh <= '0;
            end else begin
                case (r_fsm)
                    IDLE: begin
                        if (w_accept) begin
                            if (in_data == HDR) r_fsm <= RULE;
                            else                r_err <= 1'b1;
                        end
                    end
                    RULE: begin
                        if (w_accept) begin
                            r_rule_sh <= in_data;
                            r_idx     <= '0;
                            r_fsm     <= DATA;
                        end
                    end
                    DATA: begin
                        if (w_accept) begin
                            r_state_sh <= w_state_merged;
                            if (r_idx == LAST_IDX) begin
                                r_fsm       <= COMMIT;
                                r_idx       <= '0;
                                r_rule      <= r_rule_sh;
                                r_state     <= w_state_merged;
                                r_set_state <= 1'b1;
                                r_frames    <= r_frames + 8'd1;
                                r_in_ready  <= 1'b0;
                            end else begin
                                r_idx <= r_idx + 1'b1;
                            end
                        end
                    end
                    COMMIT:  r_fsm <= IDLE;
                    default: r_fsm <= IDLE;
                endcase
            end
        end
    end

    assign in_ready  = r_in_ready;
    assign rule      = r_rule;
    assign state     = r_state;
    assign set_state = r_set_state;
    assign err       = r_err;
    assign frames    = r_frames;
    assign busy      = (r_fsm != IDLE);

endmodule
